// File: rtl/axil_reg_arbiter_pkg.sv
// Shared definitions for the AXI4-Lite register arbiter.
//   state_t      : controller states
//   RESP_*       : AXI response codes
//   AXI_WSTRB    : write strobe driven on every write (full-word writes only)
//   AXI_PROT     : protection bits driven on AW/AR (unprivileged, secure, data)
package axil_reg_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] AXI_WSTRB = 4'hF;
  localparam logic [2:0] AXI_PROT  = 3'b000;

endpackage

// File: rtl/axil_reg_arbiter_rr.sv
// Round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   accept     : the current grant is taken this cycle; advance the pointer
//   grant      : one-hot grant (zero when no request)
//   grant_idx  : binary index of the granted requester
// The pointer names the requester with highest priority; after a grant it
// moves to the requester following the one granted.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Scan from the farthest offset down to the pointer so the nearest
  // requesting index (in rotated order) is the last one written.
  always_comb begin : p_grant
    logic [IW-1:0] idx;
    grant     = '0;
    grant_idx = ptr_q;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axil_reg_arbiter.sv
// Shares one AXI4-Lite master port among C_NUM_REQ simple requesters.
//   ACLK, ARESETN            : clock, asynchronous active-low reset
//   req_valid/we/addr/wdata  : per-requester command (slice i = requester i)
//   req_ready                : one-hot accept pulse
//   rsp_valid/rdata/err      : one-cycle response pulse to the command owner
//   M_AXI_*                  : AXI4-Lite master channels AW, W, B, AR, R
// One command is in flight at a time. Illegal addresses are answered with an
// error without touching the bus; every wait on the slave is bounded by
// C_TIMEOUT cycles per state.
module axil_reg_arbiter
  import axil_reg_arbiter_pkg::*;
#(
  parameter int C_NUM_REQ    = 2,
  parameter int C_ADDR_WIDTH = 8,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_REGS   = 50,
  parameter int C_TIMEOUT    = 255
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_NUM_REQ-1:0]              req_valid,
  output logic [C_NUM_REQ-1:0]              req_ready,
  input  logic [C_NUM_REQ-1:0]              req_we,
  input  logic [C_NUM_REQ*C_ADDR_WIDTH-1:0] req_addr,
  input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_wdata,
  output logic [C_NUM_REQ-1:0]              rsp_valid,
  output logic [C_DATA_WIDTH-1:0]           rsp_rdata,
  output logic                              rsp_err,
  output logic [C_ADDR_WIDTH-1:0]           M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]           M_AXI_WDATA,
  output logic [3:0]                        M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]           M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]           M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int          IW         = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
  localparam int          TW         = $clog2(C_TIMEOUT + 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * C_NUM_REGS);

  state_t                    state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      we_q, we_d;
  logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [IW-1:0]             owner_q, owner_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [C_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [C_NUM_REQ-1:0]      grant;
  logic [IW-1:0]             grant_idx;
  logic                      idle;
  logic [C_ADDR_WIDTH-1:0]   sel_addr;
  logic [31:0]               addr_ext;
  logic                      addr_legal;
  logic                      timed_out;

  assign idle = (state_q == ST_IDLE);

  // Requests are only presented in IDLE, so grant doubles as req_ready.
  rr_arbiter #(.N(C_NUM_REQ)) u_rr (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .req       (req_valid & {C_NUM_REQ{idle}}),
    .accept    (|grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;

  // Channel VALID/READY follow the state so a timeout (forced DONE) or a
  // reset drops them in the same cycle the state changes.
  assign M_AXI_AWVALID = (state_q == ST_WR_REQ) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == ST_WR_REQ) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
  assign M_AXI_ARVALID = (state_q == ST_RD_REQ);
  assign M_AXI_RREADY  = (state_q == ST_RD_RESP);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = AXI_WSTRB;
  assign M_AXI_AWPROT  = AXI_PROT;
  assign M_AXI_ARPROT  = AXI_PROT;

  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    rsp_valid = '0;
    if (state_q == ST_DONE) rsp_valid[owner_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    sel_addr = req_addr[grant_idx*C_ADDR_WIDTH +: C_ADDR_WIDTH];
    addr_ext = '0;
    addr_ext[C_ADDR_WIDTH-1:0] = sel_addr;
    addr_legal = (sel_addr[1:0] == 2'b00) && (addr_ext < ADDR_LIMIT);
    timed_out  = (timer_q >= TW'(C_TIMEOUT));

    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          we_d      = req_we[grant_idx];
          addr_d    = sel_addr;
          wdata_d   = req_wdata[grant_idx*C_DATA_WIDTH +: C_DATA_WIDTH];
          owner_d   = grant_idx;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (!addr_legal) begin
            state_d     = ST_DONE;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (req_we[grant_idx]) begin
            state_d = ST_WR_REQ;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        aw_done_d = aw_done_q | (M_AXI_AWVALID & M_AXI_AWREADY);
        w_done_d  = w_done_q  | (M_AXI_WVALID  & M_AXI_WREADY);
        if (aw_done_d && w_done_d) begin
          state_d = ST_WR_RESP;
        end else if (timed_out) begin
          state_d     = ST_DONE;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          state_d     = ST_DONE;
          rsp_err_d   = (M_AXI_BRESP != RESP_OKAY);
          rsp_rdata_d = '0;
        end else if (timed_out) begin
          state_d     = ST_DONE;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      ST_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          state_d = ST_RD_RESP;
        end else if (timed_out) begin
          state_d     = ST_DONE;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      ST_RD_RESP: begin
        if (M_AXI_RVALID) begin
          state_d     = ST_DONE;
          rsp_err_d   = (M_AXI_RRESP != RESP_OKAY);
          rsp_rdata_d = M_AXI_RDATA;
        end else if (timed_out) begin
          state_d     = ST_DONE;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The counter measures time spent in the current wait state only.
    if (state_d != state_q || state_q == ST_IDLE || state_q == ST_DONE) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Bench for axil_reg_arbiter: directed steps plus randomized commands, checked
// against a register-bank model of what each command must return.
module tb_axil_reg_arbiter;
  import axil_reg_arbiter_pkg::*;

  localparam int N     = 2;
  localparam int NREGS = 50;
  localparam int TO    = 255;

  logic        clk, rst_n;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axil_reg_arbiter #(.C_NUM_REQ(N), .C_ADDR_WIDTH(8), .C_DATA_WIDTH(32),
                     .C_NUM_REGS(NREGS), .C_TIMEOUT(TO)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc, axi_act;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (awvalid || wvalid || arvalid) axi_act <= axi_act + 1;
  end

  // ---------------- AXI4-Lite slave with configurable wait states ----------
  int         aw_lat, w_lat, ar_lat, r_lat;
  logic [1:0] b_cfg, r_cfg;
  int         aw_cnt, w_cnt, ar_cnt, r_cnt;
  logic       aw_got, w_got, r_pend;
  logic [7:0] aw_addr_s;
  logic [31:0] w_data_s, r_data_s;
  logic [31:0] smem [0:NREGS-1];

  assign awready = awvalid && (aw_cnt >= aw_lat);
  assign wready  = wvalid  && (w_cnt  >= w_lat);
  assign arready = arvalid && (ar_cnt >= ar_lat);

  wire        aw_hs  = awvalid && awready;
  wire        w_hs   = wvalid && wready;
  wire        ar_hs  = arvalid && arready;
  wire        aw_all = aw_got || aw_hs;
  wire        w_all  = w_got || w_hs;
  wire        commit = aw_all && w_all;
  wire [7:0]  c_addr = aw_hs ? awaddr : aw_addr_s;
  wire [31:0] c_data = w_hs ? wdata : w_data_s;
  wire [31:0] rd_val = (araddr < 8'(4 * NREGS)) ? smem[araddr[7:2]] : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) smem[i] <= 32'(i * 7 + 1);
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00;
      rdata <= '0; aw_addr_s <= '0; w_data_s <= '0; r_data_s <= '0;
    end else begin
      aw_cnt <= (awvalid && !aw_hs) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !w_hs) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !ar_hs) ? ar_cnt + 1 : 0;
      if (aw_hs) aw_addr_s <= awaddr;
      if (w_hs)  w_data_s <= wdata;
      if (bvalid && bready) bvalid <= 1'b0;
      if (commit) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        bvalid <= 1'b1; bresp <= b_cfg;
        if (b_cfg == 2'b00 && c_addr < 8'(4 * NREGS)) smem[c_addr[7:2]] <= c_data;
      end else if (!awvalid && !wvalid) begin
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= aw_all; w_got <= w_all;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (ar_hs) begin
        if (r_lat == 0) begin
          rvalid <= 1'b1; rdata <= rd_val; rresp <= r_cfg;
        end else begin
          r_pend <= 1'b1; r_cnt <= 1; r_data_s <= rd_val;
        end
      end else if (r_pend && !rvalid) begin
        if (r_cnt >= r_lat) begin
          rvalid <= 1'b1; rdata <= r_data_s; rresp <= r_cfg; r_pend <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
    end
  end

  // ---------------- reference model and checking ---------------------------
  int          checks, errors;
  logic [31:0] ref_mem [0:NREGS-1];
  int          ref_last;

  task automatic ref_reset();
    for (int i = 0; i < NREGS; i++) ref_mem[i] = 32'(i * 7 + 1);
    ref_last = N - 1;  // so requester 0 is next in line
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input int who);
    int n;
    n = 0;
    #1;
    while (req_ready == 2'b00 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("grant", 32'(req_ready), 32'(1 << who));
  endtask

  task automatic run_cmd(input int who, input logic we, input logic [7:0] addr,
                         input logic [31:0] data, input logic [1:0] resp, input bit stall,
                         input string tag, output int lat, output int act);
    bit          legal;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          n, g_cyc, act0;
    legal   = (addr[1:0] == 2'b00) && (int'(addr) < 4 * NREGS);
    exp_err = !legal || stall || (resp != RESP_OKAY);
    exp_rd  = '0;
    if (legal && !stall && !we) exp_rd = ref_mem[addr[7:2]];
    if (legal && !stall && we && resp == RESP_OKAY) ref_mem[addr[7:2]] = data;

    @(negedge clk);
    req_valid[who] = 1'b1;
    req_we[who] = we;
    req_addr[who*8 +: 8] = addr;
    req_wdata[who*32 +: 32] = data;
    act0 = axi_act;
    wait_grant(who);
    g_cyc = cyc;
    ref_last = who;
    @(negedge clk);
    req_valid[who] = 1'b0;
    n = 0;
    while (rsp_valid == 2'b00 && n < 400) begin
      @(negedge clk); n++;
    end
    lat = cyc - g_cyc;
    check({tag, "_owner"}, 32'(rsp_valid), 32'(1 << who));
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    @(negedge clk);
    act = axi_act - act0;
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    $display("txn %s req=%0d we=%0d addr=%02h wdata=%08h err=%0d rdata=%08h lat=%0d",
             tag, who, we, addr, data, exp_err, exp_rd, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, act, n, exp_g, who, sel;
    logic we_r;
    logic [7:0] addr_r;
    logic [31:0] dat_r;
    logic [1:0] resp_r;
    logic [1:0] seen;

    checks = 0; errors = 0;
    aw_lat = 0; w_lat = 0; ar_lat = 0; r_lat = 0; b_cfg = RESP_OKAY; r_cfg = RESP_OKAY;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    ref_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", 32'({req_ready, rsp_valid, rsp_err, awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait write from requester 0.
    run_cmd(0, 1'b1, 8'h04, 32'h0000_0002, RESP_OKAY, 1'b0, "wr04", lat, act);
    check("wr04_latency", 32'(lat), 32'd3);

    // Illegal addresses: beyond the bank and misaligned.
    run_cmd(1, 1'b0, 8'hC8, 32'h0, RESP_OKAY, 1'b0, "rdC8", lat, act);
    check("rdC8_noaxi", 32'(act), 32'd0);
    run_cmd(1, 1'b0, 8'h06, 32'h0, RESP_OKAY, 1'b0, "rd06", lat, act);
    check("rd06_noaxi", 32'(act), 32'd0);

    // Both requesters reading continuously: grants must rotate.
    @(negedge clk);
    req_valid = 2'b11; req_we = 2'b00; req_addr = {8'h04, 8'h04};
    for (int t = 0; t < 4; t++) begin
      exp_g = (ref_last + 1) % N;
      wait_grant(exp_g);
      ref_last = exp_g;
      n = 0;
      @(negedge clk);
      while (rsp_valid == 2'b00 && n < 50) begin @(negedge clk); n++; end
      check("rr_owner", 32'(rsp_valid), 32'(1 << exp_g));
      check("rr_rdata", rsp_rdata, ref_mem[1]);
      $display("txn rr grant=%0d rdata=%08h", exp_g, ref_mem[1]);
    end
    req_valid = 2'b00;

    // Slave error on write, then both AW/W orderings.
    b_cfg = RESP_SLVERR;
    run_cmd(0, 1'b1, 8'h10, 32'hAAAA_5555, RESP_SLVERR, 1'b0, "wr10_slverr", lat, act);
    b_cfg = RESP_OKAY;
    run_cmd(1, 1'b0, 8'h10, 32'h0, RESP_OKAY, 1'b0, "rd10", lat, act);
    aw_lat = 2; w_lat = 0;
    run_cmd(0, 1'b1, 8'h14, 32'h1234_5678, RESP_OKAY, 1'b0, "wr14_wfirst", lat, act);
    aw_lat = 0; w_lat = 2;
    run_cmd(1, 1'b1, 8'h18, 32'h8765_4321, RESP_OKAY, 1'b0, "wr18_awfirst", lat, act);
    w_lat = 0;
    run_cmd(0, 1'b0, 8'h14, 32'h0, RESP_OKAY, 1'b0, "rd14", lat, act);
    run_cmd(1, 1'b0, 8'h18, 32'h0, RESP_OKAY, 1'b0, "rd18", lat, act);

    // AWREADY stuck low: command must time out and the next one succeed.
    aw_lat = 300;
    run_cmd(0, 1'b1, 8'h08, 32'hFEED_0008, RESP_OKAY, 1'b1, "wr08_timeout", lat, act);
    check("timeout_window", 32'(lat >= TO && lat <= TO + 5), 32'd1);
    check("timeout_awvalid", 32'(awvalid), 32'd0);
    aw_lat = 0;
    run_cmd(1, 1'b1, 8'h08, 32'hC0DE_0008, RESP_OKAY, 1'b0, "wr08", lat, act);
    run_cmd(0, 1'b0, 8'h08, 32'h0, RESP_OKAY, 1'b0, "rd08", lat, act);

    // Randomized commands with random wait states and responses.
    for (int t = 0; t < 24; t++) begin
      who  = int'($urandom_range(0, 1));
      we_r = 1'($urandom_range(0, 1));
      sel  = int'($urandom_range(0, 9));
      if (sel == 0)      addr_r = 8'(4 * NREGS + 4 * $urandom_range(0, 13));
      else if (sel == 1) addr_r = 8'($urandom_range(0, NREGS - 1) * 4 + $urandom_range(1, 3));
      else               addr_r = 8'($urandom_range(0, NREGS - 1) * 4);
      dat_r  = $urandom;
      resp_r = ($urandom_range(0, 4) == 0) ? RESP_SLVERR : RESP_OKAY;
      aw_lat = int'($urandom_range(0, 3)); w_lat = int'($urandom_range(0, 3));
      ar_lat = int'($urandom_range(0, 3)); r_lat = int'($urandom_range(0, 3));
      b_cfg = resp_r; r_cfg = resp_r;
      run_cmd(who, we_r, addr_r, dat_r, resp_r, 1'b0, "rand", lat, act);
      if (sel <= 1) check("rand_noaxi", 32'(act), 32'd0);
      else if (aw_lat == 0 && w_lat == 0 && ar_lat == 0 && r_lat == 0)
        check("rand_latency", 32'(lat), 32'd3);
    end
    aw_lat = 0; w_lat = 0; ar_lat = 0; r_lat = 30; b_cfg = RESP_OKAY; r_cfg = RESP_OKAY;

    // Reset while waiting for read data.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[7:0] = 8'h04;
    wait_grant(0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (!rready && n < 20) begin @(negedge clk); n++; end
    check("rst_in_rd_resp", 32'(rready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({req_ready, rsp_valid, rsp_err, awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    check("midrst_rdata", rsp_rdata, 32'd0);
    seen = '0;
    repeat (3) begin @(negedge clk); seen |= rsp_valid; end
    rst_n = 1'b1;
    r_lat = 0;
    ref_reset();
    repeat (10) begin @(negedge clk); seen |= rsp_valid; end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    req_valid = 2'b11; req_we = 2'b00; req_addr = {8'h04, 8'h00};
    #1;
    check("rst_rr_ptr", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    run_cmd(0, 1'b0, 8'h00, 32'h0, RESP_OKAY, 1'b0, "rd00_after_rst", lat, act);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_reg_arbiter.md
AXIL_REG_ARBITER -- requirements
Module: axil_reg_arbiter

Interface
REQ-001 Parameter C_NUM_REQ, default 2, number of requesters sharing the register bank (2..4).
REQ-002 Parameter C_ADDR_WIDTH, default 8, AXI4-Lite byte-address width.
REQ-003 Parameter C_DATA_WIDTH, default 32, data width (only 32 is legal).
REQ-004 Parameter C_NUM_REGS, default 50, number of 32-bit registers in the target slave.
REQ-005 Parameter C_TIMEOUT, default 255, maximum cycles waited per AXI channel handshake.
REQ-006 ACLK  in  1  single clock; all logic is rising-edge.
REQ-007 ARESETN  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  C_NUM_REQ  per-requester command valid.
REQ-009 req_ready  out  C_NUM_REQ  one-hot command-accept pulse.
REQ-010 req_we  in  C_NUM_REQ  1=write, 0=read.
REQ-011 req_addr  in  C_NUM_REQ*C_ADDR_WIDTH  byte address; slice i belongs to requester i.
REQ-012 req_wdata  in  C_NUM_REQ*32  write data; slice i belongs to requester i.
REQ-013 rsp_valid  out  C_NUM_REQ  one-cycle response pulse to the owning requester.
REQ-014 rsp_rdata  out  32  read data, valid with rsp_valid.
REQ-015 rsp_err  out  1  error flag, valid with rsp_valid.
REQ-016 M_AXI_AW*/W*/B*/AR*/R* master AXI4-Lite ports: AWADDR/ARADDR C_ADDR_WIDTH, WDATA/RDATA 32, WSTRB 4 driven 4'hF, AWPROT/ARPROT 3 driven 3'b000, xRESP 2, plus VALID/READY on every channel.

Function
REQ-017 States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-018 In IDLE with any req_valid set, the round-robin arbiter grants exactly one requester, pulses its req_ready in that cycle and latches we/addr/wdata/owner.
REQ-019 Round-robin: priority starts at the requester after the last granted one; after reset requester 0 has highest priority.
REQ-020 A latched address that is misaligned (addr[1:0]!=0) or >= 4*C_NUM_REGS goes directly to DONE with rsp_err=1 and rsp_rdata=0; no AXI transaction is issued.
REQ-021 A legal write enters WR_REQ and asserts AWVALID and WVALID in the next cycle; each drops independently the cycle after its own handshake; both complete -> WR_RESP.
REQ-022 WR_RESP asserts BREADY; on BVALID, rsp_err=(BRESP!=2'b00), go to DONE.
REQ-023 A legal read enters RD_REQ and asserts ARVALID; on ARREADY -> RD_RESP with RREADY asserted; on RVALID, capture RDATA, rsp_err=(RRESP!=2'b00), go to DONE.
REQ-024 VALID signals, once asserted, stay asserted with stable address/data until handshake (AXI rule).
REQ-025 DONE pulses rsp_valid for the owner for exactly one cycle, then returns to IDLE; no new grant occurs in DONE.
REQ-026 Best-case latency, req_ready to rsp_valid: 3 cycles for a read or write with zero-wait slave.
REQ-027 A per-state timeout counter resets on state entry; reaching C_TIMEOUT in WR_REQ/WR_RESP/RD_REQ/RD_RESP forces DONE with rsp_err=1, rsp_rdata=0, deasserts all AXI VALID/READY.
REQ-028 req_valid deasserting after grant does not cancel the transaction.
REQ-029 rsp_rdata holds its last value between responses; after a write it is 0.

Reset
REQ-030 On ARESETN low: state=IDLE, all VALID/READY outputs, req_ready, rsp_valid, rsp_err=0, rsp_rdata=0, RR pointer=requester 0, timeout counter=0.
REQ-031 Reset asserted mid-transaction aborts it immediately; no rsp_valid is generated for the aborted command.

Structure
REQ-032 Package axil_reg_arbiter_pkg holds the state enum, AXI RESP constants (OKAY, SLVERR) and the fixed WSTRB/PROT values.
REQ-033 Sub-module rr_arbiter (request vector in, one-hot grant out, pointer update on accept) is instantiated once.

Verification
REQ-034 Req0 write addr 0x04 data 0x00000002, zero-wait slave -> AW/W handshake, rsp_valid[0] 3 cycles after req_ready[0], rsp_err=0.
REQ-035 Req0 and req1 both read 0x04 continuously -> grants alternate 0,1,0,1; each gets rdata 0x00000002.
REQ-036 Req1 read addr 0xC8 (reg 50) and addr 0x06 -> no AXI activity, rsp_err=1, rdata=0 each.
REQ-037 Slave holds AWREADY low 300 cycles -> rsp_err=1 after C_TIMEOUT, AWVALID dropped, next command serviced normally.
REQ-038 Slave returns BRESP=SLVERR -> rsp_err=1; WREADY before AWREADY and reverse order both complete correctly.
REQ-039 ARESETN low during RD_RESP -> all outputs zero, no rsp_valid, subsequent read of 0x00 returns 0x00000001.
